// File: rtl/obj_pixel_fetcher_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | obj_pixel_fetcher_if : evaluator request and VRAM read bus           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface obj_pixel_fetcher_if;
   logic        sprite_fetch;
   logic [10:0] sprite_addr;
   logic [7:0]  sprite_attr;
   logic [3:0]  sprite_index;
   logic        sprite_fetch_done;
   logic        vram_rd;
   logic [11:0] vram_addr;
   logic        vram_bank;
   logic [7:0]  vram_data;

   modport master (
      output sprite_fetch, sprite_addr, sprite_attr, sprite_index, vram_data,
      input  sprite_fetch_done, vram_rd, vram_addr, vram_bank
   );

   modport slave (
      input  sprite_fetch, sprite_addr, sprite_attr, sprite_index, vram_data,
      output sprite_fetch_done, vram_rd, vram_addr, vram_bank
   );
endinterface
`default_nettype wire

// File: rtl/obj_pixel_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | obj_pixel_fetcher : fetches sprite tile planes and merges them into  |
// | an 8-slot object pixel FIFO. Option macro: OBJ_PIX_INDEX_EN.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module obj_pixel_fetcher #(
   parameter int VRAM_LAT = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               ce,
   input  logic               isGBC,
   input  logic               lcd_on,
   input  logic               line_start,
   obj_pixel_fetcher_if.slave bus,
   input  logic               pix_shift,
   output logic               busy,
   output logic [1:0]         pix_color,
   output logic [2:0]         pix_pal,
   output logic               pix_prio
`ifdef OBJ_PIX_INDEX_EN
   ,
   output logic [3:0]         pix_index
`endif
);

   localparam int c_SLOTS = 8;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      ATTR0 = 4'd1,
      ATTR1 = 4'd2,
      RD_LO = 4'd3,
      WT_LO = 4'd4,
      RD_HI = 4'd5,
      WT_HI = 4'd6,
      MERGE = 4'd7,
      DONE  = 4'd8
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_lo;
   logic [1:0] r_col  [c_SLOTS];
   logic [2:0] r_pal  [c_SLOTS];
   logic       r_prio [c_SLOTS];
`ifdef OBJ_PIX_INDEX_EN
   logic [3:0] r_idx  [c_SLOTS];
`endif
   logic [1:0] w_new_col [c_SLOTS];
   logic [2:0] w_new_pal;
   logic       w_clear;
   logic       w_unused;

   // lcd_on=0 and line_start both act as a full soft clear and outrank the FSM
   assign w_clear   = ~reset_n | (ce & (~lcd_on | line_start));
   assign w_new_pal = isGBC ? bus.sprite_attr[2:0] : {2'b00, bus.sprite_attr[4]};

   genvar g;
   generate
      for (g = 0; g < c_SLOTS; g++) begin : g_merge
         assign w_new_col[g] = bus.sprite_attr[5] ? {bus.vram_data[g],     r_lo[g]}
                                                  : {bus.vram_data[7 - g], r_lo[7 - g]};
      end
   endgenerate

   always_comb begin
      w_state_nxt           = r_state;
      bus.vram_rd           = 1'b0;
      bus.vram_addr         = '0;
      bus.vram_bank         = 1'b0;
      bus.sprite_fetch_done = 1'b0;
      case (r_state)
         IDLE:  if (bus.sprite_fetch) w_state_nxt = ATTR0;
         ATTR0: w_state_nxt = ATTR1;
         ATTR1: w_state_nxt = RD_LO;
         RD_LO: begin
            bus.vram_rd   = 1'b1;
            bus.vram_addr = {bus.sprite_addr, 1'b0};
            bus.vram_bank = isGBC & bus.sprite_attr[3];
            w_state_nxt   = (VRAM_LAT == 2) ? WT_LO : RD_HI;
         end
         WT_LO: w_state_nxt = RD_HI;
         RD_HI: begin
            bus.vram_rd   = 1'b1;
            bus.vram_addr = {bus.sprite_addr, 1'b1};
            bus.vram_bank = isGBC & bus.sprite_attr[3];
            w_state_nxt   = (VRAM_LAT == 2) ? WT_HI : MERGE;
         end
         WT_HI: w_state_nxt = MERGE;
         MERGE: w_state_nxt = DONE;
         DONE: begin
            bus.sprite_fetch_done = 1'b1;
            w_state_nxt           = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      // Request withdrawn before the merge: drop the sprite silently
      if ((r_state inside {ATTR0, ATTR1, RD_LO, WT_LO, RD_HI, WT_HI}) && !bus.sprite_fetch)
         w_state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_state <= IDLE;
         r_lo    <= '0;
         for (int k = 0; k < c_SLOTS; k++) begin
            r_col[k]  <= '0;
            r_pal[k]  <= '0;
            r_prio[k] <= 1'b0;
`ifdef OBJ_PIX_INDEX_EN
            r_idx[k]  <= '0;
`endif
         end
      end else if (ce) begin
         r_state <= w_state_nxt;
         if (r_state == RD_HI)
            r_lo <= bus.vram_data;
         if (r_state == MERGE) begin
            // Only empty slots take new pixels, so earlier-fetched sprites win
            for (int k = 0; k < c_SLOTS; k++) begin
               if (r_col[k] == 2'b00 && w_new_col[k] != 2'b00) begin
                  r_col[k]  <= w_new_col[k];
                  r_pal[k]  <= w_new_pal;
                  r_prio[k] <= bus.sprite_attr[7];
`ifdef OBJ_PIX_INDEX_EN
                  r_idx[k]  <= bus.sprite_index;
`endif
               end
            end
         end else if (pix_shift && r_state == IDLE) begin
            for (int k = 0; k < c_SLOTS - 1; k++) begin
               r_col[k]  <= r_col[k + 1];
               r_pal[k]  <= r_pal[k + 1];
               r_prio[k] <= r_prio[k + 1];
`ifdef OBJ_PIX_INDEX_EN
               r_idx[k]  <= r_idx[k + 1];
`endif
            end
            r_col[c_SLOTS - 1]  <= '0;
            r_pal[c_SLOTS - 1]  <= '0;
            r_prio[c_SLOTS - 1] <= 1'b0;
`ifdef OBJ_PIX_INDEX_EN
            r_idx[c_SLOTS - 1]  <= '0;
`endif
         end
      end
   end

   assign busy      = (r_state != IDLE);
   assign pix_color = r_col[0];
   assign pix_pal   = r_pal[0];
   assign pix_prio  = r_prio[0];

`ifdef OBJ_PIX_INDEX_EN
   assign pix_index = (r_col[0] != 2'b00) ? r_idx[0] : 4'd0;
   assign w_unused  = bus.sprite_attr[6];
`else
   assign w_unused  = ^{bus.sprite_attr[6], bus.sprite_index};
`endif

endmodule
`default_nettype wire

// File: tb/tb_obj_pixel_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_obj_pixel_fetcher : directed + random bench for obj_pixel_fetcher |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_obj_pixel_fetcher;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, ce, isGBC, lcd_on, line_start;
   logic       pix_shift, pix_shift2;
   logic       busy, busy2;
   logic [1:0] pix_color, pix_color2;
   logic [2:0] pix_pal, pix_pal2;
   logic       pix_prio, pix_prio2;
`ifdef OBJ_PIX_INDEX_EN
   logic [3:0] pix_index, pix_index2;
`endif

   obj_pixel_fetcher_if bus1 ();
   obj_pixel_fetcher_if bus2 ();

   obj_pixel_fetcher #(.VRAM_LAT(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .ce(ce), .isGBC(isGBC), .lcd_on(lcd_on),
      .line_start(line_start), .bus(bus1), .pix_shift(pix_shift), .busy(busy),
      .pix_color(pix_color), .pix_pal(pix_pal), .pix_prio(pix_prio)
`ifdef OBJ_PIX_INDEX_EN
      , .pix_index(pix_index)
`endif
   );

   obj_pixel_fetcher #(.VRAM_LAT(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .ce(ce), .isGBC(isGBC), .lcd_on(lcd_on),
      .line_start(line_start), .bus(bus2), .pix_shift(pix_shift2), .busy(busy2),
      .pix_color(pix_color2), .pix_pal(pix_pal2), .pix_prio(pix_prio2)
`ifdef OBJ_PIX_INDEX_EN
      , .pix_index(pix_index2)
`endif
   );

   // VRAM image indexed by {bank, addr}; read pipelines of depth 1 and 2
   logic [7:0] mem [8192];
   logic [7:0] p2a;
   always @(posedge clk) if (ce)
      bus1.vram_data <= bus1.vram_rd ? mem[{bus1.vram_bank, bus1.vram_addr}] : 8'($urandom);
   always @(posedge clk) if (ce) begin
      p2a            <= bus2.vram_rd ? mem[{bus2.vram_bank, bus2.vram_addr}] : 8'($urandom);
      bus2.vram_data <= p2a;
   end

   int total = 0;
   int bad   = 0;

   // Reference FIFO for the VRAM_LAT=1 instance
   logic [1:0] m_col  [8];
   logic [2:0] m_pal  [8];
   logic       m_prio [8];
   logic [3:0] m_idx  [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         m_col[i] = 0; m_pal[i] = 0; m_prio[i] = 0; m_idx[i] = 0;
      end
   endtask

   task automatic model_pop();
      for (int i = 0; i < 7; i++) begin
         m_col[i] = m_col[i+1]; m_pal[i] = m_pal[i+1];
         m_prio[i] = m_prio[i+1]; m_idx[i] = m_idx[i+1];
      end
      m_col[7] = 0; m_pal[7] = 0; m_prio[7] = 0; m_idx[7] = 0;
   endtask

   task automatic model_merge(input logic [7:0] lo, input logic [7:0] hi,
                              input logic [7:0] at, input logic [3:0] ix);
      for (int i = 0; i < 8; i++) begin
         int b;
         int c;
         b = at[5] ? i : 7 - i;
         c = 2 * ((int'(hi) >> b) % 2) + ((int'(lo) >> b) % 2);
         if (m_col[i] == 0 && c != 0) begin
            m_col[i]  = 2'(c);
            m_pal[i]  = isGBC ? at[2:0] : (at[4] ? 3'd1 : 3'd0);
            m_prio[i] = at[7];
            m_idx[i]  = ix;
         end
      end
   endtask

   function automatic logic get_done(input int w);
      return (w != 0) ? bus2.sprite_fetch_done : bus1.sprite_fetch_done;
   endfunction
   function automatic logic get_busy(input int w);
      return (w != 0) ? busy2 : busy;
   endfunction
   function automatic logic get_rd(input int w);
      return (w != 0) ? bus2.vram_rd : bus1.vram_rd;
   endfunction
   function automatic logic [11:0] get_addr(input int w);
      return (w != 0) ? bus2.vram_addr : bus1.vram_addr;
   endfunction
   function automatic logic get_bank(input int w);
      return (w != 0) ? bus2.vram_bank : bus1.vram_bank;
   endfunction

   task automatic set_req(input int w, input logic f, input logic [10:0] a,
                          input logic [7:0] at, input logic [3:0] ix);
      if (w != 0) begin
         bus2.sprite_fetch = f; bus2.sprite_addr = a; bus2.sprite_attr = at; bus2.sprite_index = ix;
      end else begin
         bus1.sprite_fetch = f; bus1.sprite_addr = a; bus1.sprite_attr = at; bus1.sprite_index = ix;
      end
   endtask

   // One ce cycle, with random ce=0 gaps in between
   task automatic tick();
      repeat ($urandom_range(0, 1)) begin
         ce = 1'b0; @(posedge clk); #1;
      end
      ce = 1'b1; @(posedge clk); #1;
   endtask

   task automatic do_fetch(input int w, input logic [10:0] a, input logic [7:0] at,
                           input logic [7:0] lo, input logic [7:0] hi,
                           input logic [3:0] ix, input bit hold);
      logic        bank;
      int          n;
      int          rd_cnt;
      logic [11:0] ra [2];
      logic        rb [2];
      bank = isGBC & at[3];
      mem[{bank, a, 1'b0}] = lo;
      mem[{bank, a, 1'b1}] = hi;
      ra[0] = '0; ra[1] = '0; rb[0] = 1'b0; rb[1] = 1'b0;
      set_req(w, 1'b1, a, at, ix);
      n = 1;
      rd_cnt = 0;
      while (!get_done(w) && n < 40) begin
         tick();
         n++;
         if (hold) pix_shift = 1'b1;
         if (get_rd(w)) begin
            if (rd_cnt < 2) begin
               ra[rd_cnt] = get_addr(w);
               rb[rd_cnt] = get_bank(w);
            end
            rd_cnt++;
         end
      end
      chk("done_latency", n, (w != 0) ? 9 : 7);
      chk("rd_count", rd_cnt, 2);
      chk("rd_addr_lo", ra[0], {a, 1'b0});
      chk("rd_addr_hi", ra[1], {a, 1'b1});
      chk("rd_bank", rb[1], bank);
      chk("busy_in_done", get_busy(w), 1);
      if (w == 0) begin
         model_merge(lo, hi, at, ix);
         chk("merge_slot0", pix_color, m_col[0]);
      end
      set_req(w, 1'b0, a, at, ix);
      tick();
      pix_shift = 1'b0;
      chk("done_single_pulse", get_done(w), 0);
      chk("idle_after_done", get_busy(w), 0);
      if (w == 0) chk("no_shift_while_busy", pix_color, m_col[0]);
   endtask

   task automatic drain(input string tag);
      for (int s = 0; s < 8; s++) begin
         chk({tag, "_col"}, pix_color, m_col[0]);
         chk({tag, "_pal"}, pix_pal, m_pal[0]);
         chk({tag, "_prio"}, pix_prio, m_prio[0]);
`ifdef OBJ_PIX_INDEX_EN
         chk({tag, "_idx"}, pix_index, (m_col[0] != 0) ? m_idx[0] : 4'd0);
`endif
         pix_shift = 1'b1;
         tick();
         pix_shift = 1'b0;
         model_pop();
      end
      chk({tag, "_empty"}, pix_color, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      reset_n = 1'b0; ce = 1'b0; isGBC = 1'b0; lcd_on = 1'b1; line_start = 1'b0;
      pix_shift = 1'b0; pix_shift2 = 1'b0;
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      model_clear();

      // Reset with ce low
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", bus1.sprite_fetch_done, 0);
      chk("rst_rd", bus1.vram_rd, 0);
      chk("rst_addr", bus1.vram_addr, 0);
      chk("rst_bank", bus1.vram_bank, 0);
      chk("rst_col", pix_color, 0);
      chk("rst_pal", pix_pal, 0);
      chk("rst_prio", pix_prio, 0);
      chk("rst_busy2", busy2, 0);
      reset_n = 1'b1;
      tick();

      // Plain, X-flipped and DMG palette/priority sprites
      do_fetch(0, 11'h123, 8'h00, 8'hF0, 8'h0F, 4'd1, 1'b0);
      chk("plain_first", pix_color, 1);
      drain("plain");
      do_fetch(0, 11'h2A7, 8'h20, 8'hF0, 8'h0F, 4'd2, 1'b0);
      chk("xflip_first", pix_color, 2);
      drain("xflip");
      do_fetch(0, 11'h045, 8'h90, 8'hF0, 8'h0F, 4'd3, 1'b0);
      chk("dmg_prio", pix_prio, 1);
      chk("dmg_pal", pix_pal, 1);
      drain("dmgattr");

      // Two sprites at the same X: earlier one keeps its pixels
      do_fetch(0, 11'h300, 8'h00, 8'hAA, 8'h00, 4'd4, 1'b0);
      do_fetch(0, 11'h301, 8'h00, 8'hFF, 8'hFF, 4'd5, 1'b0);
      chk("overlap_first", pix_color, 1);
      drain("overlap");

      // pix_shift held across a fetch on a populated FIFO
      do_fetch(0, 11'h410, 8'h00, 8'h3C, 8'hC3, 4'd6, 1'b0);
      do_fetch(0, 11'h411, 8'h10, 8'hFF, 8'h00, 4'd7, 1'b1);
      drain("hold");

      // Randomized sprites
      for (int it = 0; it < 6; it++) begin
         isGBC = 1'($urandom);
         repeat ($urandom_range(1, 3))
            do_fetch(0, 11'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     4'($urandom), 1'($urandom));
         drain("rand");
      end
      isGBC = 1'b0;

      // Request withdrawn mid-fetch
      do_fetch(0, 11'h055, 8'h00, 8'hC3, 8'h3C, 4'd8, 1'b0);
      set_req(0, 1'b1, 11'h0AA, 8'h00, 4'd9);
      tick(); tick();
      set_req(0, 1'b0, 11'h0AA, 8'h00, 4'd9);
      tick();
      chk("abort_busy", busy, 0);
      seen = 1'b0;
      repeat (10) begin tick(); if (bus1.sprite_fetch_done) seen = 1'b1; end
      chk("abort_no_done", seen, 0);
      drain("abort");

      // line_start clears FIFO and aborts an in-flight fetch
      do_fetch(0, 11'h321, 8'h10, 8'hFF, 8'h00, 4'd10, 1'b0);
      set_req(0, 1'b1, 11'h111, 8'h00, 4'd11);
      tick(); tick(); tick();
      chk("ls_busy_before", busy, 1);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      set_req(0, 1'b0, 11'h111, 8'h00, 4'd11);
      model_clear();
      chk("ls_busy", busy, 0);
      chk("ls_col", pix_color, 0);
      chk("ls_pal", pix_pal, 0);
      seen = 1'b0;
      repeat (10) begin tick(); if (bus1.sprite_fetch_done) seen = 1'b1; end
      chk("ls_no_done", seen, 0);
      drain("ls");

      // VRAM_LAT=2 instance, GBC bank 1 / palette 3
      isGBC = 1'b1;
      do_fetch(1, 11'h5B5, 8'h0B, 8'h81, 8'h00, 4'd12, 1'b0);
      chk("lat2_col", pix_color2, 1);
      chk("lat2_pal", pix_pal2, 3);

      // lcd_on low while waiting for the high byte
      set_req(1, 1'b1, 11'h6C6, 8'h0B, 4'd13);
      repeat (6) tick();
      chk("wthi_busy", busy2, 1);
      chk("wthi_rd", bus2.vram_rd, 0);
      lcd_on = 1'b0;
      tick();
      chk("lcdoff_busy", busy2, 0);
      chk("lcdoff_done", bus2.sprite_fetch_done, 0);
      chk("lcdoff_col", pix_color2, 0);
      chk("lcdoff_pal", pix_pal2, 0);
      lcd_on = 1'b1;
      set_req(1, 1'b0, 11'h6C6, 8'h0B, 4'd13);
      seen = 1'b0;
      repeat (10) begin tick(); if (bus2.sprite_fetch_done) seen = 1'b1; end
      chk("lcdoff_no_done", seen, 0);
      isGBC = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
